// File: rtl/spi_ml_master.sv
// spi_ml_master
//   SPI master (mode 0, MSB first) with 1, 2 or 4 data lanes. It takes words
//   from a valid/ready source and shifts them out on mosi. It captures the
//   same number of bits from miso. cs_n stays low across words until a word
//   flagged tx_last has been sent.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   cfg_lanes, cfg_div  lane mode (0=1, 1=2, 2=4, 3=1 lane) and sclk half-period
//                       minus one; both are latched when a transaction starts
//   tx_valid/ready      word handshake; tx_data word, tx_last ends transaction
//   rx_valid, rx_data   one-cycle pulse with the captured word
//   busy                high while a transaction is in progress
//   sclk, cs_n          SPI clock (idle low) and chip select (active low)
//   mosi, mosi_oe       output lanes and per-lane output enables
//   miso                input lanes
module spi_ml_master #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_lanes,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic [3:0]        mosi,
    output logic [3:0]        mosi_oe,
    input  logic [3:0]        miso
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_NEXT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state;
    logic [1:0]         lanes_q;    // normalised: 0=1 lane, 1=2 lanes, 2=4 lanes
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   half_cnt;
    logic [CNT_W-1:0]   bit_cnt;    // group index within the current word
    logic               last_q;
    logic [DATA_W-1:0]  tx_sh;
    logic [DATA_W-1:0]  rx_sh;

    logic [1:0]         acc_lanes;
    logic [DATA_W-1:0]  tx_next;
    logic [DATA_W-1:0]  rx_next;
    logic               half_done;
    logic               accept;

    // Reserved lane code 3 falls back to single-lane operation.
    function automatic logic [1:0] norm_lanes(input logic [1:0] code);
        return (code == 2'd3) ? 2'd0 : code;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] l);
        case (l)
            2'd0:    return 4'h1;
            2'd1:    return 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    // Top L bits of the word, right-aligned so mosi[L-1] carries the MSB.
    function automatic logic [3:0] top_group(input logic [DATA_W-1:0] w, input logic [1:0] l);
        case (l)
            2'd0:    return {3'b000, w[DATA_W-1]};
            2'd1:    return {2'b00, w[DATA_W-1 -: 2]};
            default: return w[DATA_W-1 -: 4];
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w, input logic [1:0] l);
        case (l)
            2'd0:    return {w[DATA_W-2:0], 1'b0};
            2'd1:    return {w[DATA_W-3:0], 2'b00};
            default: return {w[DATA_W-5:0], 4'h0};
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] sh,
                                                   input logic [3:0] m, input logic [1:0] l);
        case (l)
            2'd0:    return {sh[DATA_W-2:0], m[0]};
            2'd1:    return {sh[DATA_W-3:0], m[1:0]};
            default: return {sh[DATA_W-5:0], m[3:0]};
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] last_group(input logic [1:0] l);
        case (l)
            2'd0:    return CNT_W'(DATA_W - 1);
            2'd1:    return CNT_W'(DATA_W / 2 - 1);
            default: return CNT_W'(DATA_W / 4 - 1);
        endcase
    endfunction

    assign acc_lanes = norm_lanes(cfg_lanes);
    assign tx_next   = tx_shift(tx_sh, lanes_q);
    assign rx_next   = rx_shift(rx_sh, miso, lanes_q);
    assign half_done = (half_cnt == div_q);
    assign accept    = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            lanes_q  <= 2'd0;
            div_q    <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            last_q   <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 4'h0;
            mosi_oe  <= 4'h0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_ready <= 1'b1;
                    if (accept) begin
                        lanes_q  <= acc_lanes;
                        div_q    <= cfg_div;
                        last_q   <= tx_last;
                        tx_sh    <= tx_data;
                        mosi     <= top_group(tx_data, acc_lanes);
                        mosi_oe  <= lane_mask(acc_lanes);
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP, S_LOW: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        sclk     <= 1'b1;
                        state    <= S_HIGH;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (half_done) begin
                        // Falling edge: capture miso, then either shift the next group
                        // out or finish the word.
                        half_cnt <= '0;
                        sclk     <= 1'b0;
                        rx_sh    <= rx_next;
                        if (bit_cnt == last_group(lanes_q)) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            if (last_q) begin
                                state <= S_HOLD;
                            end else begin
                                tx_ready <= 1'b1;
                                state    <= S_NEXT;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_sh   <= tx_next;
                            mosi    <= top_group(tx_next, lanes_q);
                            state   <= S_LOW;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    // Stall with cs_n low; the following LOW phase is the data setup.
                    if (accept) begin
                        last_q   <= tx_last;
                        tx_sh    <= tx_data;
                        mosi     <= top_group(tx_data, lanes_q);
                        tx_ready <= 1'b0;
                        half_cnt <= '0;
                        state    <= S_LOW;
                    end
                end
                S_HOLD: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        cs_n     <= 1'b1;
                        mosi     <= 4'h0;
                        mosi_oe  <= 4'h0;
                        state    <= S_GAP;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ml_master.sv
// tb_spi_ml_master
//   Directed bench for spi_ml_master (DATA_W=8). miso is looped back from mosi,
//   optionally inverted per lane, so the captured word is known in advance.
module tb_spi_ml_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cfg_lanes;
    logic [7:0] cfg_div;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       sclk;
    logic       cs_n;
    logic [3:0] mosi;
    logic [3:0] mosi_oe;
    logic [3:0] miso;
    logic [3:0] miso_xor;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses = 0;
    int rx_cnt = 0;
    logic [3:0] mosi_log [64];
    logic [3:0] oe_log   [64];

    spi_ml_master #(.DATA_W(8), .DIV_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_lanes(cfg_lanes),
        .cfg_div  (cfg_div),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .mosi_oe  (mosi_oe),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    assign miso = mosi ^ miso_xor;

    always @(posedge sclk) begin
        mosi_log[pulses % 64] = mosi;
        oe_log[pulses % 64]   = mosi_oe;
        pulses = pulses + 1;
    end

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_cnt = rx_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int k;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        k = 0;
        while (tx_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (tx_ready !== 1'b1) check("send_timeout", 32'(tx_ready), 32'd1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Latency in clocks from the accepting edge to the edge raising rx_valid.
    task automatic wait_rx(output int lat);
        lat = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p0;
        int r0;
        logic ok;
        logic [3:0] oe_or;

        rst = 1'b1; cfg_lanes = 2'd0; cfg_div = 8'd0;
        tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; miso_xor = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_oe", 32'(mosi_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // 1 lane, div 0, loopback
        cfg_lanes = 2'd0; cfg_div = 8'd0; miso_xor = 4'h0;
        p0 = pulses;
        send(8'hA5, 1'b1);
        wait_rx(lat);
        check("t1_lat", 32'(lat), 32'd16);
        check("t1_rx", 32'(rx_data), 32'hA5);
        wait_idle("t1_idle");
        check("t1_pulses", 32'(pulses - p0), 32'd8);
        check("t1_cs_n", 32'(cs_n), 32'd1);
        check("t1_oe", 32'(mosi_oe), 32'd0);

        // 4 lanes, div 1, inverted loopback
        cfg_lanes = 2'd2; cfg_div = 8'd1; miso_xor = 4'hF;
        p0 = pulses;
        send(8'h3C, 1'b1);
        wait_rx(lat);
        check("t2_lat", 32'(lat), 32'd8);
        check("t2_rx", 32'(rx_data), 32'hC3);
        wait_idle("t2_idle");
        check("t2_pulses", 32'(pulses - p0), 32'd2);
        check("t2_mosi0", 32'(mosi_log[p0 % 64]), 32'h3);
        check("t2_mosi1", 32'(mosi_log[(p0 + 1) % 64]), 32'hC);
        check("t2_oe", 32'(oe_log[p0 % 64]), 32'hF);

        // 2 lanes, two words with a stall between them
        cfg_lanes = 2'd1; cfg_div = 8'd0; miso_xor = 4'h0;
        p0 = pulses; r0 = rx_cnt;
        send(8'h12, 1'b0);
        wait_rx(lat);
        check("t3_lat0", 32'(lat), 32'd8);
        check("t3_rx0", 32'(rx_data), 32'h12);
        check("t3_grp3", 32'(mosi_log[(p0 + 3) % 64]), 32'h2);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (sclk !== 1'b0 || cs_n !== 1'b0 || tx_ready !== 1'b1) ok = 1'b0;
        end
        check("t3_stall", 32'(ok), 32'd1);
        send(8'h34, 1'b1);
        wait_rx(lat);
        check("t3_lat1", 32'(lat), 32'd8);
        check("t3_rx1", 32'(rx_data), 32'h34);
        wait_idle("t3_idle");
        check("t3_pulses", 32'(pulses - p0), 32'd8);
        check("t3_rx_cnt", 32'(rx_cnt - r0), 32'd2);

        // reserved lane code behaves as 1 lane
        cfg_lanes = 2'd3; cfg_div = 8'd0;
        p0 = pulses;
        send(8'h81, 1'b1);
        wait_rx(lat);
        check("t4_lat", 32'(lat), 32'd16);
        check("t4_rx", 32'(rx_data), 32'h81);
        wait_idle("t4_idle");
        check("t4_pulses", 32'(pulses - p0), 32'd8);
        oe_or = 4'h0;
        for (int i = 0; i < 8; i++) oe_or = oe_or | oe_log[(p0 + i) % 64];
        check("t4_oe", 32'(oe_or), 32'h1);

        // cfg_div change mid-transaction is ignored until the next IDLE accept
        cfg_lanes = 2'd0; cfg_div = 8'd0;
        send(8'h5A, 1'b0);
        cfg_div = 8'd3;
        wait_rx(lat);
        check("t5_lat0", 32'(lat), 32'd16);
        check("t5_rx0", 32'(rx_data), 32'h5A);
        send(8'hC3, 1'b1);
        wait_rx(lat);
        check("t5_lat1", 32'(lat), 32'd16);
        check("t5_rx1", 32'(rx_data), 32'hC3);
        wait_idle("t5_idle0");
        send(8'h96, 1'b1);
        wait_rx(lat);
        check("t5_lat2", 32'(lat), 32'd64);
        check("t5_rx2", 32'(rx_data), 32'h96);
        wait_idle("t5_idle1");

        // reset after 3 sclk pulses
        cfg_lanes = 2'd0; cfg_div = 8'd1;
        p0 = pulses; r0 = rx_cnt;
        send(8'hFF, 1'b1);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (pulses - p0 >= 3) break;
        end
        check("t6_pulses", 32'(pulses - p0), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_cs_n", 32'(cs_n), 32'd1);
        check("t6_sclk", 32'(sclk), 32'd0);
        check("t6_oe", 32'(mosi_oe), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_no_rx", 32'(rx_cnt - r0), 32'd0);
        send(8'hE7, 1'b1);
        wait_rx(lat);
        check("t6_lat", 32'(lat), 32'd32);
        check("t6_rx", 32'(rx_data), 32'hE7);
        wait_idle("t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
